// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolution: decision, target, link, misalign and mispredict.
// Optional performance counters are compiled in with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
   parameter int XLEN    = 32,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
`ifdef BRANCH_STATS_EN
   input  logic            stats_clr,
   output logic [31:0]     cnt_resolved,
   output logic [31:0]     cnt_taken,
   output logic [31:0]     cnt_mispredict,
`endif
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_link,
   output logic [XLEN-1:0] out_redirect_pc,
   output logic            out_mispredict,
   output logic            out_misalign,
   output logic            out_illegal
);

   logic            c_taken;
   logic            c_illegal;
   logic [XLEN-1:0] c_target;
   logic [XLEN-1:0] c_link;
   logic [XLEN-1:0] jalr_sum;

   assign jalr_sum = rs1 + imm;
   assign c_link   = pc + XLEN'(4);

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      c_taken   = 1'b0;
      c_illegal = 1'b0;
      c_target  = pc + imm;
      if (is_jalr) begin
         c_taken  = 1'b1;
         c_target = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (is_jal) begin
         c_taken = 1'b1;
      end else if (is_branch) begin
         unique case (funct3)
            3'b000:  c_taken = (rs1 == rs2);
            3'b001:  c_taken = (rs1 != rs2);
            3'b100:  c_taken = ($signed(rs1) <  $signed(rs2));
            3'b101:  c_taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  c_taken = (rs1 <  rs2);
            3'b111:  c_taken = (rs1 >= rs2);
            default: c_illegal = 1'b1;
         endcase
      end
   end

   function automatic logic misalign_of(input logic t, input logic [XLEN-1:0] tgt);
      return t && (tgt[1:0] != 2'b00);
   endfunction

   // Misaligned and illegal ops trap elsewhere, so they never request a redirect.
   function automatic logic mispredict_of(input logic t, input logic [XLEN-1:0] tgt,
                                          input logic ill, input logic pt,
                                          input logic [XLEN-1:0] ptg);
      return !misalign_of(t, tgt) && !ill && ((t != pt) || (t && (tgt != ptg)));
   endfunction

   generate
      if (LATENCY == 1) begin : g_lat1
         logic adv;

         assign adv      = !out_valid || out_ready;
         assign in_ready = adv;

         // NOTE: sequential state uses non-blocking assignments under an asynchronous reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid       <= 1'b0;
               out_taken       <= 1'b0;
               out_target      <= '0;
               out_link        <= '0;
               out_redirect_pc <= '0;
               out_mispredict  <= 1'b0;
               out_misalign    <= 1'b0;
               out_illegal     <= 1'b0;
            end else if (flush) begin
               out_valid <= 1'b0;
            end else if (adv) begin
               out_valid <= in_valid;
               if (in_valid) begin
                  out_taken       <= c_taken;
                  out_target      <= c_target;
                  out_link        <= c_link;
                  out_redirect_pc <= c_taken ? c_target : c_link;
                  out_mispredict  <= mispredict_of(c_taken, c_target, c_illegal,
                                                   pred_taken, pred_target);
                  out_misalign    <= misalign_of(c_taken, c_target);
                  out_illegal     <= c_illegal;
               end
            end
         end
      end else begin : g_lat2
         logic            s1_valid;
         logic            s1_taken;
         logic            s1_illegal;
         logic [XLEN-1:0] s1_target;
         logic [XLEN-1:0] s1_link;
         logic            s1_pred_taken;
         logic [XLEN-1:0] s1_pred_target;
         logic            s1_adv;
         logic            s2_adv;

         assign s2_adv   = !out_valid || out_ready;
         assign s1_adv   = !s1_valid || s2_adv;
         assign in_ready = s1_adv;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_valid       <= 1'b0;
               s1_taken       <= 1'b0;
               s1_illegal     <= 1'b0;
               s1_target      <= '0;
               s1_link        <= '0;
               s1_pred_taken  <= 1'b0;
               s1_pred_target <= '0;
            end else if (flush) begin
               s1_valid <= 1'b0;
            end else if (s1_adv) begin
               s1_valid <= in_valid;
               if (in_valid) begin
                  s1_taken       <= c_taken;
                  s1_illegal     <= c_illegal;
                  s1_target      <= c_target;
                  s1_link        <= c_link;
                  s1_pred_taken  <= pred_taken;
                  s1_pred_target <= pred_target;
               end
            end
         end

         // Output fields load only on a real advance, so they hold while stalled.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid       <= 1'b0;
               out_taken       <= 1'b0;
               out_target      <= '0;
               out_link        <= '0;
               out_redirect_pc <= '0;
               out_mispredict  <= 1'b0;
               out_misalign    <= 1'b0;
               out_illegal     <= 1'b0;
            end else if (flush) begin
               out_valid <= 1'b0;
            end else if (s2_adv) begin
               out_valid <= s1_valid;
               if (s1_valid) begin
                  out_taken       <= s1_taken;
                  out_target      <= s1_target;
                  out_link        <= s1_link;
                  out_redirect_pc <= s1_taken ? s1_target : s1_link;
                  out_mispredict  <= mispredict_of(s1_taken, s1_target, s1_illegal,
                                                   s1_pred_taken, s1_pred_target);
                  out_misalign    <= misalign_of(s1_taken, s1_target);
                  out_illegal     <= s1_illegal;
               end
            end
         end
      end
   endgenerate

`ifdef BRANCH_STATS_EN
   logic xfer;

   assign xfer = out_valid && out_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_resolved   <= '0;
         cnt_taken      <= '0;
         cnt_mispredict <= '0;
      end else if (stats_clr) begin
         cnt_resolved   <= '0;
         cnt_taken      <= '0;
         cnt_mispredict <= '0;
      end else if (xfer) begin
         cnt_resolved   <= cnt_resolved + 32'd1;
         cnt_taken      <= cnt_taken + {31'd0, out_taken};
         cnt_mispredict <= cnt_mispredict + {31'd0, out_mispredict};
      end
   end
`endif

endmodule
